// File: rtl/trap_sequencer_if.sv
// Signal bundle between the trap sequencer and the execute stage, CSR file and PC mux.
// The master modport is the sequencer's side; the slave modport is the core's side.
interface trap_sequencer_if #(parameter int XLEN = 32);
   logic            exc_valid_i;
   logic [3:0]      exc_cause_i;
   logic            mret_i;
   logic            irq_timer_i;
   logic            irq_ext_i;
   logic [XLEN-1:0] epc_i;
   logic [XLEN-1:0] mtvec_i;
   logic [XLEN-1:0] mepc_i;
   logic [XLEN-1:0] mstatus_i;
   logic [XLEN-1:0] mie_i;
   logic            csr_we_o;
   logic [11:0]     csr_waddr_o;
   logic [XLEN-1:0] csr_wdata_o;
   logic            stall_o;
   logic            flush_o;
   logic            pc_redirect_o;
   logic [XLEN-1:0] pc_target_o;
   logic            busy_o;

   modport master (
      input  exc_valid_i, exc_cause_i, mret_i, irq_timer_i, irq_ext_i,
      input  epc_i, mtvec_i, mepc_i, mstatus_i, mie_i,
      output csr_we_o, csr_waddr_o, csr_wdata_o, stall_o, flush_o,
      output pc_redirect_o, pc_target_o, busy_o
   );

   modport slave (
      output exc_valid_i, exc_cause_i, mret_i, irq_timer_i, irq_ext_i,
      output epc_i, mtvec_i, mepc_i, mstatus_i, mie_i,
      input  csr_we_o, csr_waddr_o, csr_wdata_o, stall_o, flush_o,
      input  pc_redirect_o, pc_target_o, busy_o
   );
endinterface

// File: rtl/trap_sequencer.sv
// Machine-mode trap/MRET sequencer: freezes the pipeline, writes mepc/mcause/mstatus
// through the single CSR write port, then redirects fetch.
//
// state    | meaning
// IDLE     | watching for exception / enabled interrupt / MRET
// W_EPC    | writing mepc with captured epc
// W_CAUSE  | writing mcause with captured cause
// W_STAT   | writing mstatus for trap entry (MPIE<=MIE, MIE<=0, MPP<=M)
// RET_STAT | writing mstatus for MRET (MIE<=MPIE, MPIE<=1, MPP<=M)
// REDIR    | pc redirect + flush to captured target
module trap_sequencer #(
   parameter int XLEN = 32
) (
   input logic              clk,
   input logic              rst,
   trap_sequencer_if.master bus
);
   typedef enum logic [2:0] {
      IDLE, W_EPC, W_CAUSE, W_STAT, RET_STAT, REDIR
   } state_t;

   state_t          state, state_nxt;
   logic [XLEN-1:0] epc_q, cause_q, target_q;

   logic            ext_take, tmr_take;
   logic            take_trap, take_mret, is_irq;
   logic [XLEN-1:0] cause_d, tvec_base, trap_tgt;
   logic [XLEN-1:0] stat_trap, stat_ret;
   logic            mie_unused;

   assign mie_unused = ^{bus.mie_i[XLEN-1:12], bus.mie_i[10:8], bus.mie_i[6:0]};

   // Event detection and trap target, meaningful only in IDLE.
   always_comb begin
      ext_take  = bus.irq_ext_i   & bus.mstatus_i[3] & bus.mie_i[11];
      tmr_take  = bus.irq_timer_i & bus.mstatus_i[3] & bus.mie_i[7];
      take_trap = 1'b0;
      take_mret = 1'b0;
      is_irq    = 1'b0;
      cause_d   = '0;
      if (state == IDLE) begin
         if (bus.exc_valid_i) begin
            take_trap = 1'b1;
            cause_d   = {{(XLEN-4){1'b0}}, bus.exc_cause_i};
         end else if (ext_take) begin
            take_trap = 1'b1;
            is_irq    = 1'b1;
            cause_d   = {1'b1, {(XLEN-5){1'b0}}, 4'd11};
         end else if (tmr_take) begin
            take_trap = 1'b1;
            is_irq    = 1'b1;
            cause_d   = {1'b1, {(XLEN-5){1'b0}}, 4'd7};
         end else if (bus.mret_i) begin
            take_mret = 1'b1;
         end
      end
      tvec_base = bus.mtvec_i & {{(XLEN-2){1'b1}}, 2'b00};
      trap_tgt  = tvec_base;
      if (is_irq && bus.mtvec_i[1:0] == 2'b01)
         trap_tgt = tvec_base + {{(XLEN-6){1'b0}}, cause_d[3:0], 2'b00};

      stat_trap        = bus.mstatus_i;
      stat_trap[7]     = bus.mstatus_i[3];
      stat_trap[3]     = 1'b0;
      stat_trap[12:11] = 2'b11;
      stat_ret         = bus.mstatus_i;
      stat_ret[3]      = bus.mstatus_i[7];
      stat_ret[7]      = 1'b1;
      stat_ret[12:11]  = 2'b11;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         epc_q    <= '0;
         cause_q  <= '0;
         target_q <= '0;
      end else begin
         state <= state_nxt;
         if (take_trap) begin
            epc_q    <= bus.epc_i;
            cause_q  <= cause_d;
            target_q <= trap_tgt;
         end else if (take_mret) begin
            target_q <= bus.mepc_i;
         end
      end
   end

   always_comb begin
      state_nxt         = state;
      bus.csr_we_o      = 1'b0;
      bus.csr_waddr_o   = '0;
      bus.csr_wdata_o   = '0;
      bus.flush_o       = 1'b0;
      bus.pc_redirect_o = 1'b0;
      bus.pc_target_o   = '0;
      bus.busy_o        = (state != IDLE);
      bus.stall_o       = (state != IDLE) | take_trap | take_mret;
      unique case (state)
         IDLE: begin
            if (take_trap)      state_nxt = W_EPC;
            else if (take_mret) state_nxt = RET_STAT;
         end
         W_EPC: begin
            bus.csr_we_o    = 1'b1;
            bus.csr_waddr_o = 12'h341;
            bus.csr_wdata_o = epc_q;
            state_nxt       = W_CAUSE;
         end
         W_CAUSE: begin
            bus.csr_we_o    = 1'b1;
            bus.csr_waddr_o = 12'h342;
            bus.csr_wdata_o = cause_q;
            state_nxt       = W_STAT;
         end
         W_STAT: begin
            bus.csr_we_o    = 1'b1;
            bus.csr_waddr_o = 12'h300;
            bus.csr_wdata_o = stat_trap;
            state_nxt       = REDIR;
         end
         RET_STAT: begin
            bus.csr_we_o    = 1'b1;
            bus.csr_waddr_o = 12'h300;
            bus.csr_wdata_o = stat_ret;
            state_nxt       = REDIR;
         end
         REDIR: begin
            bus.flush_o       = 1'b1;
            bus.pc_redirect_o = 1'b1;
            bus.pc_target_o   = target_q;
            state_nxt         = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end
endmodule

// File: tb/tb_trap_sequencer.sv
// Directed bench for trap_sequencer: trap entry, vectored interrupt, masking,
// priority/back-to-back, MRET and reset mid-sequence.
module tb_trap_sequencer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests_run = 0;
   int   failed = 0;

   trap_sequencer_if bus();
   trap_sequencer dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   // The stalled pipeline must never present exception or MRET pulses.
   always @(posedge clk)
      if (!rst && bus.busy_o)
         assert (!(bus.exc_valid_i || bus.mret_i))
         else $error("FAIL protocol: event pulse while busy");

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      bus.exc_valid_i = 1'b0;
      bus.exc_cause_i = 4'd0;
      bus.mret_i      = 1'b0;
      bus.irq_timer_i = 1'b0;
      bus.irq_ext_i   = 1'b0;
      bus.epc_i       = '0;
      bus.mtvec_i     = '0;
      bus.mepc_i      = '0;
      bus.mstatus_i   = '0;
      bus.mie_i       = '0;
   endtask

   // {we, waddr, wdata, stall, flush, redirect, target, busy}
   function automatic logic [80:0] outs();
      return {bus.csr_we_o, bus.csr_waddr_o, bus.csr_wdata_o, bus.stall_o,
              bus.flush_o, bus.pc_redirect_o, bus.pc_target_o, bus.busy_o};
   endfunction

   task automatic test_reset;
      rst = 1'b1;
      idle_inputs();
      tick();
      tick();
      @(negedge clk);
      tests_run++;
      if (outs() !== 81'd0) begin
         failed++;
         $display("FAIL reset_outputs: got %h want 0", outs());
      end
      rst = 1'b0;
   endtask

   task automatic test_ecall;
      logic [11:0] ea [1:3];
      logic [31:0] ed [1:3];
      ea = '{12'h341, 12'h342, 12'h300};
      ed = '{32'h40, 32'hB, 32'h1880};
      tick();
      bus.exc_valid_i = 1'b1; bus.exc_cause_i = 4'd11; bus.epc_i = 32'h40;
      bus.mtvec_i = 32'h100; bus.mstatus_i = 32'h8;
      @(negedge clk);
      tests_run++;
      if ({bus.stall_o, bus.csr_we_o} !== 2'b10) begin
         failed++;
         $display("FAIL ecall_c0: stall/we got %b want 10", {bus.stall_o, bus.csr_we_o});
      end
      for (int c = 1; c <= 3; c++) begin
         tick();
         bus.exc_valid_i = 1'b0;
         @(negedge clk);
         tests_run++;
         if ({bus.csr_we_o, bus.csr_waddr_o, bus.csr_wdata_o, bus.stall_o, bus.pc_redirect_o}
             !== {1'b1, ea[c], ed[c], 1'b1, 1'b0}) begin
            failed++;
            $display("FAIL ecall_write%0d: got we=%b a=%h d=%h st=%b want 1 %h %h 1",
                     c, bus.csr_we_o, bus.csr_waddr_o, bus.csr_wdata_o, bus.stall_o, ea[c], ed[c]);
         end
      end
      tick();
      @(negedge clk);
      tests_run++;
      if ({bus.pc_redirect_o, bus.flush_o, bus.pc_target_o, bus.stall_o, bus.csr_we_o}
          !== {1'b1, 1'b1, 32'h100, 1'b1, 1'b0}) begin
         failed++;
         $display("FAIL ecall_redir: got r=%b f=%b t=%h st=%b want 1 1 100 1",
                  bus.pc_redirect_o, bus.flush_o, bus.pc_target_o, bus.stall_o);
      end
      tick();
      @(negedge clk);
      tests_run++;
      if (outs() !== 81'd0) begin
         failed++;
         $display("FAIL ecall_idle: got %h want 0", outs());
      end
   endtask

   task automatic test_vectored_timer;
      logic [11:0] ea [1:3];
      logic [31:0] ed [1:3];
      ea = '{12'h341, 12'h342, 12'h300};
      ed = '{32'h80, 32'h80000007, 32'h1880};
      tick();
      bus.mtvec_i = 32'h201; bus.mstatus_i = 32'h8; bus.mie_i = 32'h80;
      bus.irq_timer_i = 1'b1; bus.epc_i = 32'h80;
      @(negedge clk);
      tests_run++;
      if (bus.stall_o !== 1'b1) begin
         failed++;
         $display("FAIL timer_c0: stall got %b want 1", bus.stall_o);
      end
      for (int c = 1; c <= 3; c++) begin
         tick();
         @(negedge clk);
         tests_run++;
         if ({bus.csr_we_o, bus.csr_waddr_o, bus.csr_wdata_o} !== {1'b1, ea[c], ed[c]}) begin
            failed++;
            $display("FAIL timer_write%0d: got we=%b a=%h d=%h want 1 %h %h",
                     c, bus.csr_we_o, bus.csr_waddr_o, bus.csr_wdata_o, ea[c], ed[c]);
         end
      end
      tick();
      bus.mstatus_i = 32'h1880;
      @(negedge clk);
      tests_run++;
      if ({bus.pc_redirect_o, bus.pc_target_o} !== {1'b1, 32'h21C}) begin
         failed++;
         $display("FAIL timer_target: got r=%b t=%h want 1 21c", bus.pc_redirect_o, bus.pc_target_o);
      end
      tick();
      @(negedge clk);
      tests_run++;
      if ({bus.stall_o, bus.busy_o} !== 2'b00) begin
         failed++;
         $display("FAIL timer_no_retake: stall/busy got %b want 00", {bus.stall_o, bus.busy_o});
      end
      bus.irq_timer_i = 1'b0;
   endtask

   task automatic test_masked;
      tick();
      bus.irq_ext_i = 1'b1; bus.mstatus_i = 32'h0; bus.mie_i = 32'h800;
      for (int c = 0; c < 20; c++) begin
         if (c == 10) begin
            bus.mstatus_i = 32'h8;
            bus.mie_i = 32'h0;
         end
         @(negedge clk);
         tests_run++;
         if ({bus.stall_o, bus.csr_we_o, bus.busy_o} !== 3'b000) begin
            failed++;
            $display("FAIL masked_c%0d: stall/we/busy got %b want 000", c,
                     {bus.stall_o, bus.csr_we_o, bus.busy_o});
         end
         tick();
      end
      bus.irq_ext_i = 1'b0;
   endtask

   task automatic test_back_to_back;
      bus.mtvec_i = 32'h100; bus.mstatus_i = 32'h8; bus.mie_i = 32'h880;
      bus.exc_valid_i = 1'b1; bus.exc_cause_i = 4'd2; bus.epc_i = 32'h10;
      bus.irq_ext_i = 1'b1; bus.irq_timer_i = 1'b1;
      tick();
      bus.exc_valid_i = 1'b0;
      tick();
      @(negedge clk);
      tests_run++;
      if ({bus.csr_waddr_o, bus.csr_wdata_o} !== {12'h342, 32'h2}) begin
         failed++;
         $display("FAIL prio_cause: got a=%h d=%h want 342 00000002", bus.csr_waddr_o, bus.csr_wdata_o);
      end
      tick();
      tick();
      bus.mstatus_i = 32'h1880;
      tick();
      @(negedge clk);
      tests_run++;
      if (bus.stall_o !== 1'b0) begin
         failed++;
         $display("FAIL prio_masked_after_return: stall got %b want 0", bus.stall_o);
      end
      tick();
      bus.mstatus_i = 32'h8;
      @(negedge clk);
      tests_run++;
      if (bus.stall_o !== 1'b1) begin
         failed++;
         $display("FAIL prio_ext_taken: stall got %b want 1", bus.stall_o);
      end
      tick();
      tick();
      @(negedge clk);
      tests_run++;
      if ({bus.csr_waddr_o, bus.csr_wdata_o} !== {12'h342, 32'h8000000B}) begin
         failed++;
         $display("FAIL prio_ext_cause: got a=%h d=%h want 342 8000000b", bus.csr_waddr_o, bus.csr_wdata_o);
      end
      tick();
      tick();
      bus.mstatus_i = 32'h1880; bus.irq_ext_i = 1'b0; bus.irq_timer_i = 1'b0;
      @(negedge clk);
      tests_run++;
      if ({bus.pc_redirect_o, bus.pc_target_o} !== {1'b1, 32'h100}) begin
         failed++;
         $display("FAIL prio_ext_target: got r=%b t=%h want 1 100", bus.pc_redirect_o, bus.pc_target_o);
      end
      tick();
   endtask

   task automatic test_mret;
      tick();
      bus.mepc_i = 32'h44; bus.mstatus_i = 32'h1880; bus.mret_i = 1'b1;
      @(negedge clk);
      tests_run++;
      if ({bus.stall_o, bus.csr_we_o} !== 2'b10) begin
         failed++;
         $display("FAIL mret_c0: stall/we got %b want 10", {bus.stall_o, bus.csr_we_o});
      end
      tick();
      bus.mret_i = 1'b0;
      @(negedge clk);
      tests_run++;
      if ({bus.csr_we_o, bus.csr_waddr_o, bus.csr_wdata_o} !== {1'b1, 12'h300, 32'h1888}) begin
         failed++;
         $display("FAIL mret_stat: got we=%b a=%h d=%h want 1 300 1888",
                  bus.csr_we_o, bus.csr_waddr_o, bus.csr_wdata_o);
      end
      tick();
      @(negedge clk);
      tests_run++;
      if ({bus.pc_redirect_o, bus.flush_o, bus.pc_target_o} !== {1'b1, 1'b1, 32'h44}) begin
         failed++;
         $display("FAIL mret_redir: got r=%b f=%b t=%h want 1 1 44",
                  bus.pc_redirect_o, bus.flush_o, bus.pc_target_o);
      end
      tick();
      @(negedge clk);
      tests_run++;
      if ({bus.busy_o, bus.stall_o} !== 2'b00) begin
         failed++;
         $display("FAIL mret_idle: busy/stall got %b want 00", {bus.busy_o, bus.stall_o});
      end
   endtask

   task automatic test_reset_mid;
      tick();
      bus.exc_valid_i = 1'b1; bus.exc_cause_i = 4'd3; bus.epc_i = 32'h60;
      bus.mtvec_i = 32'h100; bus.mstatus_i = 32'h8;
      tick();
      bus.exc_valid_i = 1'b0;
      tick();
      @(negedge clk);
      tests_run++;
      if ({bus.csr_waddr_o, bus.csr_wdata_o} !== {12'h342, 32'h3}) begin
         failed++;
         $display("FAIL rstmid_cause: got a=%h d=%h want 342 00000003", bus.csr_waddr_o, bus.csr_wdata_o);
      end
      rst = 1'b1;
      tick();
      @(negedge clk);
      tests_run++;
      if (outs() !== 81'd0) begin
         failed++;
         $display("FAIL rstmid_outputs: got %h want 0", outs());
      end
      rst = 1'b0;
      for (int c = 0; c < 4; c++) begin
         tick();
         @(negedge clk);
         tests_run++;
         if ({bus.csr_we_o, bus.busy_o} !== 2'b00) begin
            failed++;
            $display("FAIL rstmid_no_write%0d: we/busy got %b want 00", c, {bus.csr_we_o, bus.busy_o});
         end
      end
   endtask

   initial begin
      test_reset();
      test_ecall();
      test_vectored_timer();
      test_masked();
      test_back_to_back();
      test_mret();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, failed);
      $finish;
   end
endmodule

// File: doc/trap_sequencer.md
# trap_sequencer

Machine-mode trap controller for the 3-stage RISC-V core. It detects synchronous exceptions, enabled timer/external interrupts and MRET at the execute stage, and freezes the pipeline. It then writes mepc/mcause/mstatus one at a time through the CSR file's single write port, and redirects fetch to the handler or back to mepc. It sits between the execute stage, the CSR file and the PC mux.

## Interface
- XLEN, 32, datapath/CSR width
- clk  input  1  core clock
- rst  input  1  synchronous, active-high reset
- exc_valid_i  input  1  execute-stage instruction raised a synchronous exception (one-cycle pulse)
- exc_cause_i  input  4  exception code (2 illegal, 3 ebreak, 11 ecall-M)
- mret_i  input  1  execute-stage instruction is MRET (one-cycle pulse)
- irq_timer_i  input  1  timer interrupt, level
- irq_ext_i  input  1  external interrupt, level
- epc_i  input  XLEN  PC of the instruction in execute
- mtvec_i, mepc_i, mstatus_i  input  XLEN each  current CSR values from the CSR file
- mie_i  input  XLEN  current mie CSR (bit 7 MTIE, bit 11 MEIE)
- csr_we_o  output  1  CSR write strobe
- csr_waddr_o  output  12  CSR address
- csr_wdata_o  output  XLEN  CSR write data
- stall_o  output  1  hold PC and all pipeline registers
- flush_o  output  1  kill fetch/decode contents (one cycle)
- pc_redirect_o  output  1  load pc_target_o into PC (one cycle)
- pc_target_o  output  XLEN  redirect address
- busy_o  output  1  sequencer not in IDLE

## Operation
- States: IDLE, W_EPC, W_CAUSE, W_STAT, RET_STAT, REDIR.
- Event priority, evaluated only in IDLE: exc_valid_i, then external interrupt, then timer interrupt, then mret_i.
- An interrupt is taken only if mstatus_i[3] (MIE) = 1 and its mie_i enable bit = 1.
- On a trap:
  - Capture epc_i, cause and the interrupt flag into internal registers.
  - mcause = {1'b1, 27'b0, 4'd11} for external, {1'b1, 27'b0, 4'd7} for timer, {28'b0, exc_cause_i} for an exception.
  - The captured target is computed from mtvec_i in the same cycle.
  - Go to W_EPC.
- W_EPC: write 0x341 with the captured epc. Next state W_CAUSE.
- W_CAUSE: write 0x342 with the captured mcause. Next state W_STAT.
- W_STAT: write 0x300 with mstatus_i modified as MPIE(bit 7) = old MIE(bit 3), MIE = 0, MPP(bits 12:11) = 2'b11. Next state REDIR.
- On MRET: capture mepc_i as the target. Next state RET_STAT.
- RET_STAT: write 0x300 with MIE = MPIE, MPIE = 1, MPP = 2'b11. Next state REDIR.
- REDIR: assert pc_redirect_o and flush_o with pc_target_o = captured target. Next state IDLE.
- Trap target:
  - Direct (mtvec_i[1:0] = 00, or any exception): mtvec_i & ~32'h3.
  - Vectored (mtvec_i[1:0] = 01, interrupts only): (mtvec_i & ~32'h3) + 4*cause[3:0].
  - Arithmetic is modulo 2^32.
- Interrupt epc is the PC of the not-yet-executed instruction, which is re-executed after MRET.
- While busy:
  - Interrupt levels stay pending and are re-evaluated on return to IDLE.
  - exc_valid_i and mret_i pulses are ignored; the stalled pipeline must not produce them, and the bench asserts this.
- The SAVE_STATUS write uses the live mstatus_i; W_EPC and W_CAUSE writes do not touch mstatus.
- When not writing, csr_we_o = 0; csr_waddr_o and csr_wdata_o are don't-care but driven to 0.

## Timing
- Reset:
  - State = IDLE.
  - All outputs are 0: csr_we_o, csr_waddr_o, csr_wdata_o, stall_o, flush_o, pc_redirect_o, pc_target_o, busy_o.
  - Captured registers are cleared.
- rst asserted in any state returns to IDLE on the next edge. A partially written CSR sequence is abandoned; the CSR file reset handles consistency.
- stall_o = busy_o OR (IDLE AND an event is taken). It is combinational, so the execute instruction is frozen in the detection cycle (cycle 0).
- Trap: cycle 0 detect; cycles 1/2/3 write mepc/mcause/mstatus; cycle 4 redirect+flush; cycle 5 IDLE with stall_o low. Handler fetch starts in cycle 5.
- MRET: cycle 0 detect; cycle 1 mstatus write; cycle 2 redirect+flush; cycle 3 IDLE.
- Outputs in states W_*, RET_STAT and REDIR are registered-state decodes, with no dependence on inputs except the W_STAT/RET_STAT mstatus data.
- Back-to-back events: the earliest possible next detection is the IDLE cycle after REDIR. An interrupt still pending then, with MIE now 0, is not taken.

## Test plan
- ecall:
  - Stimulus: exc_valid_i = 1, cause 11, epc_i 0x40, mtvec_i 0x100, mstatus 0x8.
  - Required: writes 0x341←0x40, 0x342←0xB, 0x300←0x1880 in cycles 1–3; redirect to 0x100 in cycle 4; stall_o high in cycles 0–4.
- Vectored timer:
  - Stimulus: mtvec_i 0x201, MIE = 1, MTIE = 1, irq_timer_i held high.
  - Required: mcause 0x80000007; target 0x21C.
- Masked interrupt:
  - Stimulus: irq_ext_i = 1 with MIE = 0, or with MEIE = 0.
  - Required: no stall_o, no CSR writes for 20 cycles.
- Priority:
  - Stimulus: exc_valid_i, irq_ext_i and irq_timer_i all asserted in the same cycle.
  - Required: exception trap first. After return, ext interrupt is taken only when MIE is restored to 1.
- MRET:
  - Stimulus: mepc_i 0x44, mstatus_i 0x1880.
  - Required: cycle 1 write 0x300←0x1888; cycle 2 redirect to 0x44; busy_o low in cycle 3.
- Reset mid-sequence:
  - Stimulus: rst asserted in W_CAUSE.
  - Required: next cycle all outputs 0 and no mstatus write is issued.
